// File: rtl/tube_controller.sv
// Memory-mapped four-digit seven-segment controller: DATA/CTRL (and optional RAW) registers on the CPU data bus.
// Optional raw-drive register enabled by defining TUBE_RAW_MODE_EN.
module tube_controller #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0010,
    parameter int          SCAN_DIV  = 10000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] MemBus_Address,
    input  logic [31:0] MemBus_Write_Data,
    input  logic        MemWrite,
    input  logic        MemRead,
    output logic [31:0] Device_Read_Data,
    output logic [3:0]  tube_select,
    output logic [7:0]  tube_segment,
    output logic        debug_state
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SCAN = 1'b1;

    localparam int              PW         = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(SCAN_DIV - 1);

    logic [29:0] word_addr;
    logic        sel_data;
    logic        sel_ctrl;

    logic [15:0]   data_q;
    logic [11:0]   ctrl_q;
    logic [0:0]    state_q;
    logic [PW-1:0] presc_q;
    logic [1:0]    idx_q;

    logic       wr_data;
    logic       wr_ctrl;
    logic       next_en;
    logic       scan_go;
    logic [3:0] nibble;
    logic [3:0] dp_mask;
    logic [3:0] blank_mask;
    logic [3:0] next_sel;
    logic [7:0] next_seg;

    logic unused_bits;
    assign unused_bits = ^{MemBus_Address[1:0], MemBus_Write_Data[31:16]};

`ifdef TUBE_RAW_MODE_EN
    logic        sel_raw;
    logic        wr_raw;
    logic [12:0] raw_q;
`endif

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    assign word_addr = MemBus_Address[31:2];
    assign sel_data  = (word_addr == BASE_ADDR[31:2]);
    assign sel_ctrl  = (word_addr == (BASE_ADDR[31:2] + 30'd1));
    assign wr_data   = MemWrite && sel_data;
    assign wr_ctrl   = MemWrite && sel_ctrl;

`ifdef TUBE_RAW_MODE_EN
    assign sel_raw = (word_addr == (BASE_ADDR[31:2] + 30'd2));
    assign wr_raw  = MemWrite && sel_raw;
`endif

    // A disable write takes effect on the same edge, overriding any terminal count.
    assign next_en = wr_ctrl ? MemBus_Write_Data[0] : ctrl_q[0];
    assign scan_go = ctrl_q[0] && next_en;

    assign dp_mask    = ctrl_q[7:4];
    assign blank_mask = ctrl_q[11:8];
    assign debug_state = state_q[0];

    always_comb begin
        nibble   = data_q[{idx_q, 2'b00} +: 4];
        next_sel = 4'b0001 << idx_q;
        next_seg = blank_mask[idx_q] ? 8'h00 : {dp_mask[idx_q], hex7(nibble)};
`ifdef TUBE_RAW_MODE_EN
        if (raw_q[12]) begin
            next_sel = raw_q[11:8];
            next_seg = raw_q[7:0];
        end
`endif
    end

    // Reads observe register contents before any same-cycle store.
    always_comb begin
        Device_Read_Data = 32'h0;
        if (MemRead) begin
            if (sel_data) begin
                Device_Read_Data = {16'h0, data_q};
            end else if (sel_ctrl) begin
                Device_Read_Data = {20'h0, ctrl_q};
            end
`ifdef TUBE_RAW_MODE_EN
            else if (sel_raw) begin
                Device_Read_Data = {19'h0, raw_q};
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            data_q       <= 16'h0;
            ctrl_q       <= 12'h0;
            state_q      <= ST_IDLE;
            presc_q      <= '0;
            idx_q        <= 2'd0;
            tube_select  <= 4'h0;
            tube_segment <= 8'h00;
`ifdef TUBE_RAW_MODE_EN
            raw_q        <= 13'h0;
`endif
        end else begin
            if (wr_data) data_q <= MemBus_Write_Data[15:0];
            if (wr_ctrl) ctrl_q <= MemBus_Write_Data[11:0];
`ifdef TUBE_RAW_MODE_EN
            if (wr_raw) raw_q <= MemBus_Write_Data[12:0];
`endif
            if (scan_go) begin
                state_q      <= ST_SCAN;
                tube_select  <= next_sel;
                tube_segment <= next_seg;
                if (presc_q == PRESC_LAST) begin
                    presc_q <= '0;
                    idx_q   <= idx_q + 2'd1;
                end else begin
                    presc_q <= presc_q + 1'b1;
                end
            end else begin
                state_q      <= ST_IDLE;
                presc_q      <= '0;
                idx_q        <= 2'd0;
                tube_select  <= 4'h0;
                tube_segment <= 8'h00;
            end
        end
    end

endmodule

// File: tb/tb_tube_controller.sv
// Self-checking bench for tube_controller with a short scan divider; expected values queued in exp_q.
module tb_tube_controller;

    localparam logic [31:0] BASE = 32'h4000_0010;
    localparam int          DIV  = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] MemBus_Address;
    logic [31:0] MemBus_Write_Data;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] Device_Read_Data;
    logic [3:0]  tube_select;
    logic [7:0]  tube_segment;
    logic        debug_state;

    logic [31:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    tube_controller #(.BASE_ADDR(BASE), .SCAN_DIV(DIV)) dut (
        .clk               (clk),
        .reset             (reset),
        .MemBus_Address    (MemBus_Address),
        .MemBus_Write_Data (MemBus_Write_Data),
        .MemWrite          (MemWrite),
        .MemRead           (MemRead),
        .Device_Read_Data  (Device_Read_Data),
        .tube_select       (tube_select),
        .tube_segment      (tube_segment),
        .debug_state       (debug_state)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pop_exp();
        if (exp_q.size() > 0) return exp_q.pop_front();
        return 32'hFFFF_FFFF;
    endfunction

    // All driver tasks start and end at a falling edge.
    task automatic check_out(input string tag);
        check(tag, {20'h0, tube_select, tube_segment}, pop_exp());
    endtask

    task automatic push_out(input logic [3:0] sel, input logic [7:0] seg);
        exp_q.push_back({20'h0, sel, seg});
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        MemBus_Address    = addr;
        MemBus_Write_Data = data;
        MemWrite          = 1'b1;
        @(negedge clk);
        MemWrite          = 1'b0;
    endtask

    task automatic bus_read(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        MemBus_Address = addr;
        MemRead        = 1'b1;
        exp_q.push_back(exp);
        #1;
        check(tag, Device_Read_Data, pop_exp());
        @(negedge clk);
        MemRead = 1'b0;
    endtask

    logic [11:0] scan_tab[4];

    initial begin
        scan_tab[0] = 12'h171;
        scan_tab[1] = 12'h277;
        scan_tab[2] = 12'h45B;
        scan_tab[3] = 12'h806;

        reset = 1'b0;
        MemWrite = 1'b0;
        MemRead = 1'b0;
        MemBus_Address = 32'h0;
        MemBus_Write_Data = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        push_out(4'h0, 8'h00);
        check_out("reset_out");
        bus_read("reset_data", BASE, 32'h0);
        bus_read("reset_ctrl", BASE + 32'd4, 32'h0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            push_out(4'h0, 8'h00);
            check_out("idle_out");
        end

        // scan sequence
        bus_write(BASE, 32'h0000_12AF);
        bus_write(BASE + 32'd4, 32'h1);
        push_out(4'h0, 8'h00);
        check_out("scan_pre");
        for (int p = 0; p < 8 * DIV; p++) exp_q.push_back({20'h0, scan_tab[(p / DIV) % 4]});
        for (int p = 0; p < 8 * DIV; p++) begin
            @(negedge clk);
            check_out("scan_seq");
        end

        // disable on the terminal cycle of digit 2
        bus_write(BASE + 32'd4, 32'h0);
        bus_write(BASE + 32'd4, 32'h1);
        repeat (3 * DIV - 1) @(negedge clk);
        push_out(4'h4, 8'h5B);
        check_out("pre_collision");
        bus_write(BASE + 32'd4, 32'h0);
        push_out(4'h0, 8'h00);
        check_out("collision_off");
        @(negedge clk);
        push_out(4'h0, 8'h00);
        check_out("collision_idle");
        bus_write(BASE + 32'd4, 32'h1);
        push_out(4'h0, 8'h00);
        check_out("reenable_pre");
        @(negedge clk);
        push_out(4'h1, 8'h71);
        check_out("reenable_digit0");

        // dp and blank masks, write-to-display latency
        bus_write(BASE + 32'd4, 32'h0);
        bus_write(BASE + 32'd4, 32'h0211);
        @(negedge clk);
        push_out(4'h1, 8'hF1);
        check_out("dp_digit0");
        bus_write(BASE, 32'h0000_12A3);
        push_out(4'h1, 8'hF1);
        check_out("data_old");
        @(negedge clk);
        push_out(4'h1, 8'hCF);
        check_out("data_latency");
        repeat (2) @(negedge clk);
        push_out(4'h2, 8'h00);
        check_out("blank_digit1");
        @(negedge clk);
        push_out(4'h2, 8'h00);
        check_out("blank_digit1_hold");

        // bus decode
        bus_write(BASE, 32'hFFFF_1234);
        bus_read("data_readback", BASE, 32'h0000_1234);
        bus_read("data_byte_offset", BASE + 32'd3, 32'h0000_1234);
        bus_read("ctrl_readback", BASE + 32'd4, 32'h0000_0211);
        bus_read("unmapped_read", BASE + 32'd12, 32'h0);
        MemBus_Address = BASE;
        exp_q.push_back(32'h0);
        #1;
        check("no_read_strobe", Device_Read_Data, pop_exp());
        @(negedge clk);
        MemBus_Address    = BASE;
        MemBus_Write_Data = 32'h0000_5555;
        MemWrite = 1'b1;
        MemRead  = 1'b1;
        exp_q.push_back(32'h0000_1234);
        #1;
        check("read_during_write", Device_Read_Data, pop_exp());
        @(negedge clk);
        MemWrite = 1'b0;
        MemRead  = 1'b0;
        bus_read("after_rw", BASE, 32'h0000_5555);
        bus_write(BASE + 32'd12, 32'hFFFF_FFFF);
        bus_read("unmapped_write", BASE, 32'h0000_5555);
`ifndef TUBE_RAW_MODE_EN
        bus_write(BASE + 32'd8, 32'h0000_1A5C);
        bus_read("raw_absent", BASE + 32'd8, 32'h0);
`endif

        // reset mid-scan with a concurrent store
        reset             = 1'b0;
        MemBus_Address    = BASE;
        MemBus_Write_Data = 32'h0000_BEEF;
        MemWrite          = 1'b1;
        @(negedge clk);
        reset    = 1'b1;
        MemWrite = 1'b0;
        push_out(4'h0, 8'h00);
        check_out("mid_reset_out");
        bus_read("mid_reset_data", BASE, 32'h0);
        bus_read("mid_reset_ctrl", BASE + 32'd4, 32'h0);

`ifdef TUBE_RAW_MODE_EN
        bus_write(BASE, 32'h0000_12AF);
        bus_write(BASE + 32'd4, 32'h1);
        bus_write(BASE + 32'd8, 32'h0000_1A5C);
        push_out(4'h1, 8'h71);
        check_out("raw_pre");
        @(negedge clk);
        push_out(4'hA, 8'h5C);
        check_out("raw_out");
        bus_read("raw_readback", BASE + 32'd8, 32'h0000_1A5C);
        repeat (3) @(negedge clk);
        push_out(4'hA, 8'h5C);
        check_out("raw_hold");
        bus_write(BASE + 32'd8, 32'h0);
        push_out(4'hA, 8'h5C);
        check_out("raw_clear_edge");
        @(negedge clk);
        push_out(4'h2, 8'h77);
        check_out("raw_resume_idx1");
        @(negedge clk);
        push_out(4'h4, 8'h5B);
        check_out("raw_resume_idx2");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
